rom_fetch_ctrl: RTL and testbench

// - Sequencer/arbiter for the single-port 1024x32 instruction ROM (sync read, addr sampled at posedge,

---
 rtl/rom_ctrl_pkg.sv | 19 +
 rtl/rom_fetch_ctrl_if.sv | 29 ++
 rtl/rom_fetch_ctrl_fetch_fifo.sv | 47 ++++
 rtl/rom_fetch_ctrl.sv | 85 ++++++++
 tb/tb_rom_fetch_ctrl.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/rom_ctrl_pkg.sv
// rom_ctrl_pkg: shared types and default widths for the ROM fetch controller.
package rom_ctrl_pkg;
  localparam int ROM_ADDR_W = 10;
  localparam int ROM_DATA_W = 32;

  typedef enum logic [1:0] {GNT_IDLE, GNT_FETCH, GNT_DBG} grant_e;

  typedef struct packed {
    logic                  valid;
    grant_e                kind;
    logic [ROM_ADDR_W-1:0] pc;
    logic                  epoch;
  } flight_t;

  typedef struct packed {
    logic [ROM_DATA_W-1:0] instr;
    logic [ROM_ADDR_W-1:0] pc;
  } fifo_entry_t;
endpackage

// File: rtl/rom_fetch_ctrl_if.sv
// rom_fetch_ctrl_if: ROM port, decode stream, redirect and debug-read signals of the fetch controller.
interface rom_fetch_ctrl_if
  import rom_ctrl_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_instr;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_data;

  modport slave (
    output rom_addr, out_valid, out_instr, out_pc, dbg_ack, dbg_data,
    input  rom_instr, redirect_valid, redirect_pc, out_ready, dbg_req, dbg_addr
  );
  modport master (
    input  rom_addr, out_valid, out_instr, out_pc, dbg_ack, dbg_data,
    output rom_instr, redirect_valid, redirect_pc, out_ready, dbg_req, dbg_addr
  );
endinterface

// File: rtl/rom_fetch_ctrl_fetch_fifo.sv
// fetch_fifo: small sync FIFO of fetched instructions with flush and occupancy count.
module fetch_fifo
  import rom_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  fifo_entry_t   din,
  output fifo_entry_t   dout,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  fifo_entry_t mem [DEPTH];
  logic [PW-1:0] wr, rd;
  logic do_push, do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && count != '0;
  assign do_push = push && (count != CW'(DEPTH) || do_pop);
  assign dout = mem[rd];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= inc(wr);
      if (do_pop) rd <= inc(rd);
      count <= count + CW'(do_push) - CW'(do_pop);
    end

  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr] <= din;
endmodule

// File: rtl/rom_fetch_ctrl.sv
// rom_fetch_ctrl: fetch sequencer/arbiter for a sync-read instruction ROM shared with a debug reader.
// Define FETCH_BYPASS_EN to forward arriving fetch data straight to decode when the buffer is empty.
module rom_fetch_ctrl
  import rom_ctrl_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 2,
  parameter int DBG_STARVE_MAX = 8
) (
  input logic clk,
  input logic rst_n,
  rom_fetch_ctrl_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(DBG_STARVE_MAX + 1);
  logic [ADDR_W-1:0] pc, fetch_pc, cur_pc, held_pc;
  logic [DATA_W-1:0] cur_instr, held_instr, dbg_data;
  logic [SW-1:0] starve;
  logic [CW-1:0] count;
  logic epoch, live, arr, byp, fifo_valid, ovalid, pop, push, dbg_busy, can_fetch, dbg_ack;
  flight_t flight;
  grant_e gnt;
  fifo_entry_t din, fifo_out;

  // Stale-epoch fetches are excluded from the credit since they will never be pushed.
  always_comb begin
    live = flight.valid && flight.kind == GNT_FETCH && flight.epoch == epoch;
    arr = live && !bus.redirect_valid;
    fifo_valid = count != '0;
`ifdef FETCH_BYPASS_EN
    byp = arr && !fifo_valid;
`else
    byp = 1'b0;
`endif
    ovalid = fifo_valid || byp;
    cur_instr = fifo_valid ? fifo_out.instr : bus.rom_instr;
    cur_pc = fifo_valid ? fifo_out.pc : flight.pc;
    pop = ovalid && bus.out_ready;
    push = arr && !(byp && bus.out_ready);
    din = '{instr: bus.rom_instr, pc: flight.pc};
    dbg_busy = (flight.valid && flight.kind == GNT_DBG) || dbg_ack;
    can_fetch = bus.redirect_valid || int'(count) + int'(live) - int'(pop) < FIFO_DEPTH;
    fetch_pc = bus.redirect_valid ? bus.redirect_pc : pc;
    gnt = bus.dbg_req && !dbg_busy && (!can_fetch || starve == SW'(DBG_STARVE_MAX)) ? GNT_DBG :
          can_fetch ? GNT_FETCH : GNT_IDLE;
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk, .rst_n, .flush(bus.redirect_valid), .push, .pop(bus.out_ready),
    .din, .dout(fifo_out), .count
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      epoch <= 1'b0;
      flight <= '0;
      starve <= '0;
      dbg_ack <= 1'b0;
      dbg_data <= '0;
      held_instr <= '0;
      held_pc <= '0;
    end else begin
      pc <= gnt == GNT_FETCH ? fetch_pc + 1'b1 : fetch_pc;
      epoch <= epoch ^ bus.redirect_valid;
      flight <= '{valid: gnt != GNT_IDLE, kind: gnt, pc: fetch_pc, epoch: epoch ^ bus.redirect_valid};
      starve <= !bus.dbg_req || gnt == GNT_DBG ? '0 :
                starve == SW'(DBG_STARVE_MAX) ? starve : starve + 1'b1;
      dbg_ack <= flight.valid && flight.kind == GNT_DBG;
      if (flight.valid && flight.kind == GNT_DBG) dbg_data <= bus.rom_instr;
      if (ovalid) begin
        held_instr <= cur_instr;
        held_pc <= cur_pc;
      end
    end

  assign bus.rom_addr = gnt == GNT_DBG ? bus.dbg_addr : fetch_pc;
  assign bus.out_valid = ovalid;
  assign bus.out_instr = ovalid ? cur_instr : held_instr;
  assign bus.out_pc = ovalid ? cur_pc : held_pc;
  assign bus.dbg_ack = dbg_ack;
  assign bus.dbg_data = dbg_data;
endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// tb_rom_fetch_ctrl: scoreboard bench for rom_fetch_ctrl against a preloaded sync-read ROM model.
module tb_rom_fetch_ctrl;
  localparam int STARVE = 8;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0;
  logic rst_n;
  int n_checks = 0;
  int n_fail = 0;
  logic [9:0] exp_pc[$];
  logic [31:0] exp_dbg[$];

  rom_fetch_ctrl_if bus ();
  rom_fetch_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) bus.rom_instr <= 32'hA5000000 | {22'b0, bus.rom_addr};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_instr", 64'(bus.out_instr), 64'd0);
    check("rst_out_pc", 64'(bus.out_pc), 64'd0);
    check("rst_dbg_ack", 64'(bus.dbg_ack), 64'd0);
    check("rst_dbg_data", 64'(bus.dbg_data), 64'd0);
    check("rst_rom_addr", 64'(bus.rom_addr), 64'd0);
  endtask

  task automatic push_run(input logic [9:0] start, input int n);
    exp_pc.delete();
    for (int i = 0; i < n; i++) exp_pc.push_back(start + 10'(i));
  endtask

  task automatic wait_first(input string tag);
    int k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!bus.out_valid && k < 8);
    check(tag, 64'(k), 64'(LAT));
  endtask

  task automatic wait_pc(input logic [9:0] target, input string tag);
    int k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!(bus.out_valid && bus.out_pc == target) && k < 64);
    check(tag, 64'(bus.out_valid && bus.out_pc == target), 64'd1);
  endtask

  // Every decode transfer must be the next expected address and its ROM word.
  always @(negedge clk)
    if (rst_n && !bus.redirect_valid && bus.out_valid && bus.out_ready) begin
      if (exp_pc.size() == 0) check("extra_out", 64'(bus.out_pc), 64'h3ff_ffff);
      else begin
        logic [9:0] p;
        p = exp_pc.pop_front();
        check("out_pc", 64'(bus.out_pc), 64'(p));
        check("out_instr", 64'(bus.out_instr), 64'(32'hA5000000 | {22'b0, p}));
      end
    end

  always @(negedge clk)
    if (rst_n && bus.dbg_ack) begin
      if (exp_dbg.size() == 0) check("dbg_spurious", 64'd1, 64'd0);
      else check("dbg_data", 64'(bus.dbg_data), 64'(exp_dbg.pop_front()));
    end

  initial begin
    int ack_k, bubbles;
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.dbg_req = 1'b0;
    bus.dbg_addr = '0;
    repeat (3) @(posedge clk);
    #1 check_reset();
    rst_n = 1'b1;
    push_run(10'h000, 40);
    wait_first("lat_reset");
    // decode stalls for 6 cycles after taking pc 3
    wait_pc(10'h003, "wait_pc3");
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("stall_rom_addr", 64'(bus.rom_addr), 64'h006);
    check("stall_valid", 64'(bus.out_valid), 64'd1);
    check("stall_pc", 64'(bus.out_pc), 64'h004);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_pc(10'h005, "wait_pc5");
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 10'h3F0;
    push_run(10'h3F0, 20);
    @(posedge clk);
    #1 bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_next_valid", 64'(bus.out_valid), 64'(LAT == 1));
    wait_pc(10'h3F3, "wait_pc3f3");
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 10'h3FE;
    push_run(10'h3FE, 60);
    @(posedge clk);
    #1 bus.redirect_valid = 1'b0;
    repeat (4) @(posedge clk);
    // debug read against a continuous fetch stream
    #1 bus.dbg_req = 1'b1;
    bus.dbg_addr = 10'h100;
    exp_dbg.push_back(32'hA5000100);
    ack_k = -1;
    bubbles = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.out_valid) bubbles++;
      if (bus.dbg_ack && ack_k < 0) ack_k = k;
      @(posedge clk);
      #1;
      if (ack_k >= 0) bus.dbg_req = 1'b0;
    end
    check("dbg_latency", 64'(ack_k >= 0 && ack_k <= STARVE + 3), 64'd1);
    check("dbg_bubbles", 64'(bubbles), 64'd1);
    // reset while a debug read is in flight
    bus.out_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.dbg_req = 1'b1;
    bus.dbg_addr = 10'h155;
    exp_dbg.push_back(32'hA5000155);
    @(posedge clk);
    #1 rst_n = 1'b0;
    bus.dbg_req = 1'b0;
    exp_dbg.delete();
    exp_pc.delete();
    #1 check_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_no_ack", 64'(bus.dbg_ack), 64'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    push_run(10'h000, 40);
    wait_first("lat_restart");
    repeat (12) @(posedge clk);
    check("dbg_pending", 64'(exp_dbg.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
